seg7_sequencer: RTL
===================

# seg7_sequencer

Sequencing controller for the 7-segment message decoder: generates the 4-bit `counter` index that walks the decoder through the message characters at 0 to LAST_IDX. It supplies a programmable character rate, forward and reverse scrolling, pause and single-step, direct index load, and a blank gap between message repeats. The blank gap drives index 4'hF, which the decoder renders as all segments off. The block sits between the top-level control inputs and the decoder's `counter` input.

## Interface
- TICK_DIV, default 10_000_000: clock cycles per character step; legal range ≥2.
- LAST_IDX, default 9: final message index; legal range 1..14.
- GAP_TICKS, default 2: blank ticks inserted at each wrap; 0 disables the gap.
- clk  in  1  single clock for the whole block.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  level input; 1 scrolls, 0 pauses.
- step  in  1  one-cycle pulse; advances one index. Honoured only while STOPPED.
- dir  in  1  0 = ascending index, 1 = descending; sampled at each advance.
- load  in  1  one-cycle pulse; forces `counter` to `load_idx`.
- load_idx  in  4  index for `load`. Values above LAST_IDX clamp to LAST_IDX.
- counter  out  4  registered index to the decoder; 4'hF during the blank gap.
- tick  out  1  registered one-cycle pulse on each prescaler terminal count.
- wrap  out  1  registered one-cycle pulse when the message end is passed.
- busy  out  1  1 in RUNNING or BLANK.

## Operation
- States:
  - STOPPED: hold the index.
  - RUNNING: advance on each tick.
  - BLANK: output 4'hF for GAP_TICKS ticks.
- Reset values: state=STOPPED, counter=0, prescaler=0, gap count=0, tick=0, wrap=0, busy=0.
- Prescaler counts 0..TICK_DIV-1 only in RUNNING or BLANK. It clears in STOPPED and on `load`.
- STOPPED -> RUNNING when run=1. The prescaler starts from 0, so the first advance comes TICK_DIV cycles later.
- RUNNING on tick:
  - dir=0: counter+1. If counter was LAST_IDX, the message has ended.
  - dir=1: counter-1. If counter was 0, the message has ended.
  - At message end: assert wrap. If GAP_TICKS>0, set counter=4'hF and enter BLANK. Otherwise set counter=0 (dir=0) or LAST_IDX (dir=1) directly.
- BLANK: counts GAP_TICKS ticks. On the last one, counter=0 (dir=0) or LAST_IDX (dir=1), then return to RUNNING.
- run=0 in RUNNING: go to STOPPED at the next edge and hold counter.
- run=0 in BLANK: go to STOPPED. counter takes the restart value immediately, so STOPPED never shows 4'hF.
- step in STOPPED: advance one index by `dir` on the next edge. Wrap is immediate with no blank gap, and wrap pulses. step is ignored in other states.
- load: highest priority in every state.
  - counter = min(load_idx, LAST_IDX).
  - Prescaler and gap count clear.
  - Next state is RUNNING if run=1, else STOPPED. A BLANK in progress is abandoned.
- Simultaneous inputs:
  - load with step: load wins, step is dropped.
  - load with terminal count: load wins, tick still pulses, no advance.
- Width: counter is 4 bits. Arithmetic never produces a value outside 0..LAST_IDX or 4'hF.

## Timing
- Edge E is the clock edge on which the prescaler is at TICK_DIV-1. From E+1, tick=1 for one cycle, counter holds the new value and wrap is valid. All three are registered together.
- step/load latency: counter updates on the first edge after the cycle where the pulse is sampled high.
- busy follows the state register with zero added latency.
- Async rst: all registers take their reset values immediately, mid-tick or mid-gap. The first tick after release comes TICK_DIV cycles after run=1 is sampled.
- Steady-state character period is exactly TICK_DIV cycles. Full message period is (LAST_IDX+1+GAP_TICKS)×TICK_DIV cycles.

## Test plan
All scenarios use TICK_DIV=4, LAST_IDX=9, GAP_TICKS=2.
- Reset then run=1, dir=0 -> counter 0,1,…,9 with changes 4 cycles apart. Then wrap pulse with counter=F for 8 cycles, then counter=0. Exactly one tick per 4 cycles.
- run=1, dir=1 from 0 -> wrap with counter=F for 2 ticks, then 9,8,…. Toggle dir mid-message at counter=5 -> next value is 6.
- run=0 at counter=3, then three step pulses -> 4,5,6. Further steps from 9 -> 0 with wrap=1 and no F. busy=0 throughout.
- load_idx=12 pulsed while RUNNING at counter=7 -> counter=9 next cycle, next advance 4 cycles later. load during BLANK with run=0 -> counter=load value, state STOPPED.
- rst asserted asynchronously mid-BLANK -> counter=0, tick=wrap=busy=0 immediately, with no clock edge needed.
- load and step in the same cycle while STOPPED -> counter=load_idx, no extra advance, wrap=0.

Source files
------------

// File: rtl/seg7_seq_if.sv
// Control and index bus between the top-level controls and the 7-segment
// message sequencer.
interface seg7_seq_if;
  logic       run;
  logic       step;
  logic       dir;
  logic       load;
  logic [3:0] load_idx;
  logic [3:0] counter;
  logic       tick;
  logic       wrap;
  logic       busy;

  modport master (
    output run, step, dir, load, load_idx,
    input  counter, tick, wrap, busy
  );

  modport slave (
    input  run, step, dir, load, load_idx,
    output counter, tick, wrap, busy
  );
endinterface

// File: rtl/seg7_sequencer.sv
// Sequencer for the 7-segment message decoder. It walks a 4-bit index over
// 0..LAST_IDX at a programmable rate, scrolls in either direction, and
// supports pause/single-step and direct load. Between repeats it can insert
// a blank gap, shown as index 4'hF.
module seg7_sequencer #(
  parameter int TICK_DIV  = 10_000_000,
  parameter int LAST_IDX  = 9,
  parameter int GAP_TICKS = 2
) (
  input  logic       clk,
  input  logic       rst,
  seg7_seq_if.slave  bus
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

  localparam logic [3:0]    LAST      = 4'(LAST_IDX);
  localparam logic [3:0]    BLANK_IDX = 4'hF;
  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_TICKS - 1);

  typedef enum logic [1:0] {
    ST_STOPPED,
    ST_RUNNING,
    ST_BLANK
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            tick_q, tick_d;
  logic            wrap_q, wrap_d;
  logic            tc;
  logic [4:0]      adv;

  // One step in the given direction: {message_end, next_index}. At the end
  // the returned index is the restart value for that direction.
  function automatic logic [4:0] advance(input logic [3:0] idx, input logic down);
    if (!down) begin
      if (idx >= LAST) return {1'b1, 4'd0};
      return {1'b0, idx + 4'd1};
    end
    if (idx == 4'd0 || idx > LAST) return {1'b1, LAST};
    return {1'b0, idx - 4'd1};
  endfunction

  function automatic logic [3:0] restart(input logic down);
    return down ? LAST : 4'd0;
  endfunction

  function automatic logic [3:0] clamp(input logic [3:0] idx);
    return (idx > LAST) ? LAST : idx;
  endfunction

  // Next-state, prescaler, gap and output computation; load overrides all.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    presc_d = '0;
    gap_d   = gap_q;
    wrap_d  = 1'b0;
    tc      = (state_q != ST_STOPPED) && (presc_q == PRE_LAST);
    tick_d  = tc;
    adv     = advance(cnt_q, bus.dir);

    if (state_q != ST_STOPPED && !tc) begin
      presc_d = presc_q + PW'(1);
    end

    if (bus.load) begin
      cnt_d   = clamp(bus.load_idx);
      presc_d = '0;
      gap_d   = '0;
      state_d = bus.run ? ST_RUNNING : ST_STOPPED;
    end else begin
      unique case (state_q)
        ST_STOPPED: begin
          if (bus.step) begin
            cnt_d  = adv[3:0];
            wrap_d = adv[4];
          end
          if (bus.run) state_d = ST_RUNNING;
        end
        ST_RUNNING: begin
          if (!bus.run) begin
            state_d = ST_STOPPED;
            presc_d = '0;
          end else if (tc) begin
            cnt_d = adv[3:0];
            if (adv[4]) begin
              wrap_d = 1'b1;
              if (GAP_TICKS > 0) begin
                cnt_d   = BLANK_IDX;
                gap_d   = '0;
                state_d = ST_BLANK;
              end
            end
          end
        end
        ST_BLANK: begin
          if (!bus.run) begin
            // Leave the gap showing the restart index, never 4'hF.
            state_d = ST_STOPPED;
            cnt_d   = restart(bus.dir);
            gap_d   = '0;
            presc_d = '0;
          end else if (tc) begin
            if (gap_q == GAP_LAST) begin
              cnt_d   = restart(bus.dir);
              gap_d   = '0;
              state_d = ST_RUNNING;
            end else begin
              gap_d = gap_q + GW'(1);
            end
          end
        end
        default: begin
          state_d = ST_STOPPED;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_STOPPED;
      cnt_q   <= 4'd0;
      presc_q <= '0;
      gap_q   <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
      gap_q   <= gap_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.counter = cnt_q;
  assign bus.tick    = tick_q;
  assign bus.wrap    = wrap_q;
  assign bus.busy    = (state_q != ST_STOPPED);

endmodule
